// File: rtl/data_mem_responder_if.sv
// Request/response bundle types and the core <-> responder data-memory
// handshake interface (core is master, responder is slave).
package data_mem_pkg;
   typedef struct packed {
      logic [31:0] write_data;
      logic        valid;
      logic        wen;
      logic        byte_not_word;
      logic        yumi;
   } mem_in_s;

   typedef struct packed {
      logic [31:0] read_data;
      logic        valid;
      logic        yumi;
   } mem_out_s;
endpackage

interface data_mem_if;
   import data_mem_pkg::*;

   mem_in_s     mem_in_i;
   logic [31:0] mem_addr_i;
   mem_out_s    mem_out_o;

   modport master (
      output mem_in_i,
      output mem_addr_i,
      input  mem_out_o
   );

   modport slave (
      input  mem_in_i,
      input  mem_addr_i,
      output mem_out_o
   );
endinterface

// File: rtl/data_mem_responder.sv
// Responder end of the data-memory valid/yumi handshake: word-addressed
// SRAM, one request in flight, fixed-latency response held until yumi.
module data_mem_responder
   import data_mem_pkg::*;
#(
   parameter int addr_width_p = 10,
   parameter int latency_p    = 2
) (
   input  logic       clk,
   input  logic       reset,
   data_mem_if.slave  mem,
   output logic       busy_o
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

   state_e      state;
   logic [3:0]  cnt;
   logic [31:0] read_data;
   logic        resp_v;

   logic [31:0] mem_r [2**addr_width_p];

   logic [addr_width_p-1:0] widx;
   logic [1:0]              lane;
   logic                    accept;
   logic [31:0]             word;
   logic [31:0]             lane_data;
   logic                    unused_addr;

   assign widx = mem.mem_addr_i[addr_width_p+1:2];
   assign lane = mem.mem_addr_i[1:0];
   assign unused_addr = ^mem.mem_addr_i[31:addr_width_p+2];

   // Accept only from IDLE and never while reset is held.
   assign accept = reset && (state == IDLE) && mem.mem_in_i.valid;

   assign word      = mem_r[widx];
   assign lane_data = {24'b0, word[{lane, 3'b000} +: 8]};

   assign mem.mem_out_o = '{read_data: read_data,
                            valid:     resp_v,
                            yumi:      accept};

   assign busy_o = (state != IDLE);

   always_ff @(posedge clk) begin
      if (accept && mem.mem_in_i.wen) begin
         if (mem.mem_in_i.byte_not_word)
            mem_r[widx][{lane, 3'b000} +: 8] <=
               mem.mem_in_i.write_data[7:0];
         else
            mem_r[widx] <= mem.mem_in_i.write_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         read_data <= '0;
         resp_v    <= 1'b0;
         cnt       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  if (mem.mem_in_i.wen)
                     read_data <= '0;
                  else if (mem.mem_in_i.byte_not_word)
                     read_data <= lane_data;
                  else
                     read_data <= word;
                  if (latency_p == 1) begin
                     state  <= RESP;
                     resp_v <= 1'b1;
                  end else begin
                     state <= BUSY;
                     cnt   <= 4'(latency_p - 1);
                  end
               end
            end
            BUSY: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state  <= RESP;
                  resp_v <= 1'b1;
               end
            end
            RESP: begin
               if (mem.mem_in_i.yumi) begin
                  state  <= IDLE;
                  resp_v <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a word-array model
// that applies the load/store/lane rules directly.
module tb_data_mem_responder;
   import data_mem_pkg::*;

   localparam int LAT = 2;

   logic clk;
   logic reset;
   logic busy;
   logic busy1;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] ref_mem [int];

   data_mem_if bus ();
   data_mem_if bus1 ();

   data_mem_responder #(.addr_width_p(10), .latency_p(LAT)) dut (
      .clk    (clk),
      .reset  (reset),
      .mem    (bus),
      .busy_o (busy)
   );

   data_mem_responder #(.addr_width_p(10), .latency_p(1)) dut1 (
      .clk    (clk),
      .reset  (reset),
      .mem    (bus1),
      .busy_o (busy1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One full transaction on the latency-LAT instance, starting at a negedge.
   task automatic xact(input bit wen, input bit bnw,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int hold, input bit keep);
      int          idx;
      int          sh;
      logic [31:0] cur;
      logic [31:0] exp;
      idx = int'((addr >> 2) % 1024);
      sh  = 8 * int'(addr % 4);
      cur = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
      if (wen) begin
         exp = 32'h0;
         if (bnw)
            ref_mem[idx] = (cur & ~(32'hFF << sh)) | ({24'h0, wd[7:0]} << sh);
         else
            ref_mem[idx] = wd;
      end else begin
         exp = bnw ? ((cur >> sh) & 32'hFF) : cur;
      end
      bus.mem_in_i = '{write_data: wd, valid: 1'b1, wen: wen,
                       byte_not_word: bnw, yumi: 1'b0};
      bus.mem_addr_i = addr;
      #1;
      chk("accept_yumi", 32'(bus.mem_out_o.yumi), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      @(posedge clk);
      @(negedge clk);
      bus.mem_in_i.valid = keep;
      for (int k = 1; k < LAT; k++) begin
         chk("wait_valid", 32'(bus.mem_out_o.valid), 32'd0);
         chk("wait_yumi", 32'(bus.mem_out_o.yumi), 32'd0);
         chk("wait_busy", 32'(busy), 32'd1);
         @(negedge clk);
      end
      chk("resp_valid", 32'(bus.mem_out_o.valid), 32'd1);
      chk("resp_data", bus.mem_out_o.read_data, exp);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid", 32'(bus.mem_out_o.valid), 32'd1);
         chk("hold_data", bus.mem_out_o.read_data, exp);
         chk("hold_yumi", 32'(bus.mem_out_o.yumi), 32'd0);
      end
      bus.mem_in_i.yumi = 1'b1;
      #1;
      chk("ack_cycle_yumi", 32'(bus.mem_out_o.yumi), 32'd0);
      @(negedge clk);
      bus.mem_in_i.yumi = 1'b0;
      chk("drop_valid", 32'(bus.mem_out_o.valid), 32'd0);
      chk("drop_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [31:0] a;
      reset = 1'b0;
      bus.mem_in_i  = '0;
      bus.mem_in_i.valid = 1'b1;
      bus.mem_addr_i = '0;
      bus1.mem_in_i  = '0;
      bus1.mem_addr_i = '0;
      repeat (3) @(negedge clk);
      chk("rst_yumi", 32'(bus.mem_out_o.yumi), 32'd0);
      chk("rst_valid", 32'(bus.mem_out_o.valid), 32'd0);
      chk("rst_rdata", bus.mem_out_o.read_data, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      bus.mem_in_i.valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);

      xact(1, 0, 32'h10, 32'hDEADBEEF, 0, 0);
      xact(0, 0, 32'h10, 32'h0, 0, 0);

      xact(1, 0, 32'h20, 32'h11223344, 0, 0);
      xact(1, 1, 32'h22, 32'h000000AA, 0, 0);
      xact(0, 0, 32'h20, 32'h0, 0, 0);
      xact(0, 1, 32'h23, 32'h0, 0, 0);

      xact(0, 0, 32'h20, 32'h0, 5, 0);

      xact(1, 0, 32'h30, 32'hA5A5_0001, 1, 1);
      xact(0, 0, 32'h30, 32'h0, 0, 1);
      xact(0, 1, 32'h31, 32'h0, 2, 0);

      xact(1, 0, 32'h1000, 32'h12345678, 0, 0);
      xact(0, 0, 32'h0, 32'h0, 0, 0);

      // Store accepted, then reset lands while the response is pending.
      bus.mem_in_i = '{write_data: 32'h5, valid: 1'b1, wen: 1'b1,
                       byte_not_word: 1'b0, yumi: 1'b0};
      bus.mem_addr_i = 32'h8;
      ref_mem[2] = 32'h5;
      @(posedge clk);
      @(negedge clk);
      bus.mem_in_i.valid = 1'b0;
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("abort_valid", 32'(bus.mem_out_o.valid), 32'd0);
         chk("abort_busy", 32'(busy), 32'd0);
      end
      reset = 1'b1;
      @(negedge clk);
      chk("abort_after_valid", 32'(bus.mem_out_o.valid), 32'd0);
      xact(0, 0, 32'h8, 32'h0, 0, 0);

      for (int i = 0; i < 16; i++)
         xact(1, 0, 32'h100 + 32'(i * 4), $urandom, 0, 0);
      for (int t = 0; t < 150; t++) begin
         a = ($urandom & 32'hFFFF_F003) | (32'h100 + 32'($urandom_range(0, 15) * 4));
         xact(1'($urandom), 1'($urandom), a, $urandom,
              int'($urandom_range(0, 3)), (t != 149) && 1'($urandom));
      end

      bus1.mem_in_i = '{write_data: 32'hCAFEF00D, valid: 1'b1, wen: 1'b1,
                        byte_not_word: 1'b0, yumi: 1'b0};
      bus1.mem_addr_i = 32'h4;
      #1;
      chk("l1_st_yumi", 32'(bus1.mem_out_o.yumi), 32'd1);
      @(negedge clk);
      bus1.mem_in_i.valid = 1'b0;
      chk("l1_st_valid", 32'(bus1.mem_out_o.valid), 32'd1);
      chk("l1_st_data", bus1.mem_out_o.read_data, 32'd0);
      bus1.mem_in_i.yumi = 1'b1;
      @(negedge clk);
      bus1.mem_in_i = '{write_data: 32'h0, valid: 1'b1, wen: 1'b0,
                        byte_not_word: 1'b0, yumi: 1'b0};
      chk("l1_drop", 32'(bus1.mem_out_o.valid), 32'd0);
      @(negedge clk);
      bus1.mem_in_i.valid = 1'b0;
      chk("l1_ld_valid", 32'(bus1.mem_out_o.valid), 32'd1);
      chk("l1_ld_data", bus1.mem_out_o.read_data, 32'hCAFEF00D);
      chk("l1_busy", 32'(busy1), 32'd1);
      bus1.mem_in_i.yumi = 1'b1;
      @(negedge clk);
      bus1.mem_in_i.yumi = 1'b0;
      chk("l1_ld_drop", 32'(bus1.mem_out_o.valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
